reg_lock_sched: RTL and testbench

Register-lock scheduler for the issue stage. It arbitrates round-robin between NP pipeline issue requesters and owns the register lock table (scoreboard). A requester receives a one-cycle grant only when its source and destination registers are unlocked. On grant, its destination register is locked until writeback. Blocking instructions are serialised: the scheduler drains all locks, issues the blocking instruction alone, then holds all registers locked until the instruction completes.

---
 rtl/reg_lock_sched.sv | 188 ++++++++++++++++++
 tb/tb_reg_lock_sched.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_lock_sched.sv
// reg_lock_sched
//
// Issue-stage scheduler that owns the register lock table (scoreboard) and
// arbitrates round-robin between NP issue requesters.
//
// A requester gets a one-cycle grant only when its source registers and its
// destination register are all unlocked. A granted destination register stays
// locked until its writeback arrives.
//
// Blocking instructions are serialised:
//   1. Wait (DRAIN) until every lock has been released.
//   2. Issue the blocking instruction on its own.
//   3. Hold every register locked (HOLD) until blk_done_i.
//
// Ports
//   clk_i           clock, all state updates on the rising edge
//   rst_i           synchronous active-high reset
//   req_valid_i     per-requester valid
//   req_blocking_i  per-requester "instruction is blocking"
//   req_rd_i        per-requester destination register index
//   req_reg_req_i   per-requester one-hot mask of source registers
//   gnt_o           one-hot grant, combinational; instruction consumed when set
//   wb_valid_i      writeback strobe
//   wb_rd_i         register released by the writeback
//   blk_done_i      the issued blocking instruction has completed
//   locks_o         registered lock table
//   state_o         0 RUN, 1 DRAIN, 2 HOLD
module reg_lock_sched #(
   // Matches NUM_REGS of the RV64G integer register file.
   parameter int NR = 32,
   parameter int NP = 2
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NP-1:0]                   req_valid_i,
   input  logic [NP-1:0]                   req_blocking_i,
   input  logic [NP-1:0][$clog2(NR)-1:0]   req_rd_i,
   input  logic [NP-1:0][NR-1:0]           req_reg_req_i,
   output logic [NP-1:0]                   gnt_o,
   input  logic                            wb_valid_i,
   input  logic [$clog2(NR)-1:0]           wb_rd_i,
   input  logic                            blk_done_i,
   output logic [NR-1:0]                   locks_o,
   output logic [1:0]                      state_o
);

   localparam int IW = $clog2(NR);
   localparam int PW = (NP > 1) ? $clog2(NP) : 1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [NR-1:0]   locks_q, locks_d;
   logic [PW-1:0]   rr_q, rr_d;

   logic [NP-1:0]   elig;
   logic            head_found;
   logic [PW-1:0]   head_idx;
   logic            head_blk;
   logic            pick_found;
   logic [PW-1:0]   pick_idx;
   logic [NP-1:0]   gnt;

   // Hazard-free, non-blocking requesters.
   // Index 0 is never locked, so rd==0 never collides.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NP; i++) begin
         elig[i] = req_valid_i[i] && !req_blocking_i[i]
                   && ((req_reg_req_i[i] & locks_q) == '0)
                   && !((req_rd_i[i] != '0) && locks_q[req_rd_i[i]]);
      end
   end

   // Scan from rr_q with wrap-around.
   // The head is the first valid requester in scan order. The scan for an
   // eligible requester stops at the first valid blocking one, so a younger
   // requester can never overtake a pending blocking instruction.
   always_comb begin
      int            idx;
      logic [PW-1:0] idx_p;
      logic          stop;
      head_found = 1'b0;
      head_idx   = '0;
      pick_found = 1'b0;
      pick_idx   = '0;
      stop       = 1'b0;
      idx        = 0;
      idx_p      = '0;
      for (int k = 0; k < NP; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NP) idx = idx - NP;
         idx_p = PW'(idx);
         if (req_valid_i[idx_p] && !stop) begin
            if (!head_found) begin
               head_found = 1'b1;
               head_idx   = idx_p;
            end
            if (req_blocking_i[idx_p]) begin
               stop = 1'b1;
            end else if (elig[idx_p] && !pick_found) begin
               pick_found = 1'b1;
               pick_idx   = idx_p;
            end
         end
      end
   end

   assign head_blk = head_found && req_blocking_i[head_idx];

   // Next-state, grant and lock-table update.
   always_comb begin
      logic [PW-1:0] gidx;
      int            nxt;
      state_d = state_q;
      locks_d = locks_q;
      rr_d    = rr_q;
      gnt     = '0;
      gidx    = '0;
      nxt     = 0;

      case (state_q)
         ST_RUN: begin
            if (head_blk) begin
               state_d = ST_DRAIN;
            end else if (pick_found) begin
               gnt[pick_idx] = 1'b1;
               gidx          = pick_idx;
            end
         end
         ST_DRAIN: begin
            if (!head_blk) begin
               state_d = ST_RUN;
            end else if (locks_q == '0) begin
               gnt[head_idx] = 1'b1;
               gidx          = head_idx;
               state_d       = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (blk_done_i) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase

      if (state_q == ST_HOLD) begin
         // Writebacks are ignored while the blocking instruction owns
         // every register.
         if (blk_done_i) locks_d = '0;
      end else begin
         // The clear is applied first so a same-cycle grant of the same
         // register wins.
         if (wb_valid_i && (wb_rd_i != '0)) locks_d[wb_rd_i] = 1'b0;
         if (state_d == ST_HOLD) begin
            locks_d = '1;
         end else if (pick_found && (gnt != '0) && (req_rd_i[pick_idx] != '0)) begin
            locks_d[req_rd_i[pick_idx]] = 1'b1;
         end
      end

      if (gnt != '0) begin
         nxt = int'(gidx) + 1;
         if (nxt >= NP) nxt = 0;
         rr_d = PW'(nxt);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_RUN;
         locks_q <= '0;
         rr_q    <= '0;
      end else begin
         state_q <= state_d;
         locks_q <= locks_d;
         rr_q    <= rr_d;
      end
   end

   assign gnt_o   = rst_i ? '0 : gnt;
   assign locks_o = locks_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_reg_lock_sched.sv
module tb_reg_lock_sched;

   localparam int NR = 32;
   localparam int NP = 2;
   localparam int IW = $clog2(NR);

   logic                      clk = 1'b0;
   logic                      rst_i;
   logic [NP-1:0]             req_valid;
   logic [NP-1:0]             req_blk;
   logic [NP-1:0][IW-1:0]     req_rd;
   logic [NP-1:0][NR-1:0]     req_mask;
   logic [NP-1:0]             gnt;
   logic                      wb_valid;
   logic [IW-1:0]             wb_rd;
   logic                      blk_done;
   logic [NR-1:0]             locks;
   logic [1:0]                state;

   int total = 0;
   int bad   = 0;

   // Reference model state: mode 0 RUN, 1 DRAIN, 2 HOLD.
   int            m_mode;
   logic [NR-1:0] m_locks;
   int            m_rr;

   reg_lock_sched #(.NR(NR), .NP(NP)) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .req_valid_i    (req_valid),
      .req_blocking_i (req_blk),
      .req_rd_i       (req_rd),
      .req_reg_req_i  (req_mask),
      .gnt_o          (gnt),
      .wb_valid_i     (wb_valid),
      .wb_rd_i        (wb_rd),
      .blk_done_i     (blk_done),
      .locks_o        (locks),
      .state_o        (state)
   );

   always #5 clk = ~clk;

   task automatic clear_inputs();
      req_valid = '0;
      req_blk   = '0;
      req_rd    = '0;
      req_mask  = '0;
      wb_valid  = 1'b0;
      wb_rd     = '0;
      blk_done  = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      clear_inputs();
      tick();
      rst_i = 1'b0;
   endtask

   task automatic rand_inputs();
      for (int i = 0; i < NP; i++) begin
         req_valid[i] = ($urandom % 4) != 0;
         req_blk[i]   = ($urandom % 12) == 0;
         req_rd[i]    = IW'($urandom % 8);
         req_mask[i]  = '0;
         if ($urandom % 2 == 1) req_mask[i][$urandom % 8] = 1'b1;
      end
      wb_valid = ($urandom % 2) == 1;
      wb_rd    = IW'($urandom % 8);
      blk_done = ($urandom % 3) == 0;
   endtask

   // True when every source register and the destination are unlocked in
   // the model's lock table.
   function automatic bit regs_free(logic [NR-1:0] m, logic [IW-1:0] rd);
      for (int r = 0; r < NR; r++)
         if (m[r] && m_locks[r]) return 0;
      if (rd != 0 && m_locks[rd]) return 0;
      return 1;
   endfunction

   // One cycle of the scheduler behaviour, computed from the current inputs
   // and model state: which requester is granted, and the next model state.
   task automatic model_decide(output int g, output int nmode,
                               output logic [NR-1:0] nlocks, output int nrr);
      int order[$];
      int head;
      bit halted;
      g      = -1;
      nmode  = m_mode;
      nlocks = m_locks;
      nrr    = m_rr;
      head   = -1;
      halted = 0;
      for (int k = 0; k < NP; k++)
         if (req_valid[(m_rr + k) % NP]) order.push_back((m_rr + k) % NP);
      if (order.size() > 0) head = order[0];

      if (m_mode == 0) begin
         if (head >= 0 && req_blk[head]) nmode = 1;
         else
            foreach (order[j]) begin
               if (!halted && g < 0) begin
                  if (req_blk[order[j]]) halted = 1;
                  else if (regs_free(req_mask[order[j]], req_rd[order[j]])) g = order[j];
               end
            end
      end else if (m_mode == 1) begin
         if (head < 0 || !req_blk[head]) nmode = 0;
         else if (m_locks == 0) begin
            g     = head;
            nmode = 2;
         end
      end else begin
         if (blk_done) begin
            nmode  = 0;
            nlocks = '0;
         end
      end

      if (m_mode != 2) begin
         if (wb_valid && wb_rd != 0) nlocks[wb_rd] = 1'b0;
         if (nmode == 2) nlocks = '1;
         else if (g >= 0 && req_rd[g] != 0) nlocks[req_rd[g]] = 1'b1;
      end
      if (g >= 0) nrr = (g + 1) % NP;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      for (int c = 0; c < 2; c++) begin
         rand_inputs();
         #1;
         total++;
         if (gnt !== 2'b00) begin
            bad++;
            $display("FAIL reset_gnt cyc=%0d got=%b want=00", c, gnt);
         end
         tick();
      end
      rst_i = 1'b0;
      clear_inputs();
      #1;
      total++;
      if (locks !== '0) begin
         bad++;
         $display("FAIL reset_locks got=%h want=0", locks);
      end
      total++;
      if (state !== 2'd0) begin
         bad++;
         $display("FAIL reset_state got=%0d want=0", state);
      end
   endtask

   task automatic test_hazard();
      do_reset();
      req_valid[0] = 1'b1;
      req_rd[0]    = 5'd5;
      #1;
      total++;
      if (gnt !== 2'b01) begin
         bad++;
         $display("FAIL hazard_lock_gnt got=%b want=01", gnt);
      end
      tick();
      total++;
      if (locks !== 32'h20) begin
         bad++;
         $display("FAIL hazard_locked got=%h want=00000020", locks);
      end
      req_valid       = 2'b10;
      req_rd[1]       = 5'd6;
      req_mask[1]     = 32'h20;
      wb_valid        = 1'b1;
      wb_rd           = 5'd5;
      #1;
      total++;
      if (gnt !== 2'b00) begin
         bad++;
         $display("FAIL hazard_blocked got=%b want=00", gnt);
      end
      tick();
      wb_valid = 1'b0;
      total++;
      if (locks !== 32'h0) begin
         bad++;
         $display("FAIL hazard_released got=%h want=0", locks);
      end
      #1;
      total++;
      if (gnt !== 2'b10) begin
         bad++;
         $display("FAIL hazard_regrant got=%b want=10", gnt);
      end
      tick();
      clear_inputs();
      total++;
      if (locks !== 32'h40) begin
         bad++;
         $display("FAIL hazard_rd_locked got=%h want=00000040", locks);
      end
   endtask

   task automatic test_round_robin();
      logic [NP-1:0] want;
      do_reset();
      req_valid   = 2'b11;
      req_mask[0] = 32'h400;
      req_mask[1] = 32'h800;
      for (int c = 0; c < 4; c++) begin
         want = (c % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         total++;
         if (gnt !== want) begin
            bad++;
            $display("FAIL rr_gnt cyc=%0d got=%b want=%b", c, gnt, want);
         end
         tick();
      end
      clear_inputs();
      total++;
      if (locks !== 32'h0) begin
         bad++;
         $display("FAIL rr_locks got=%h want=0", locks);
      end
   endtask

   task automatic test_blocking();
      do_reset();
      req_valid[0] = 1'b1;
      req_rd[0]    = 5'd3;
      tick();
      req_rd[0]  = 5'd0;
      req_blk[0] = 1'b1;
      #1;
      total++;
      if (gnt !== 2'b00) begin
         bad++;
         $display("FAIL blk_detect_gnt got=%b want=00", gnt);
      end
      tick();
      total++;
      if (state !== 2'd1) begin
         bad++;
         $display("FAIL blk_drain_state got=%0d want=1", state);
      end
      wb_valid = 1'b1;
      wb_rd    = 5'd3;
      #1;
      total++;
      if (gnt !== 2'b00) begin
         bad++;
         $display("FAIL blk_drain_gnt got=%b want=00", gnt);
      end
      tick();
      wb_valid = 1'b0;
      #1;
      total++;
      if (gnt !== 2'b01) begin
         bad++;
         $display("FAIL blk_issue_gnt got=%b want=01", gnt);
      end
      tick();
      total++;
      if (locks !== 32'hFFFF_FFFF || state !== 2'd2) begin
         bad++;
         $display("FAIL blk_hold got locks=%h state=%0d want locks=ffffffff state=2", locks, state);
      end
      req_valid = 2'b10;
      req_blk   = 2'b00;
      wb_valid  = 1'b1;
      wb_rd     = 5'd3;
      #1;
      total++;
      if (gnt !== 2'b00) begin
         bad++;
         $display("FAIL blk_hold_gnt got=%b want=00", gnt);
      end
      tick();
      total++;
      if (locks !== 32'hFFFF_FFFF) begin
         bad++;
         $display("FAIL blk_hold_wb_ignored got=%h want=ffffffff", locks);
      end
      wb_valid = 1'b0;
      blk_done = 1'b1;
      tick();
      clear_inputs();
      total++;
      if (locks !== 32'h0 || state !== 2'd0) begin
         bad++;
         $display("FAIL blk_done got locks=%h state=%0d want locks=0 state=0", locks, state);
      end
   endtask

   task automatic test_abort_hold();
      do_reset();
      req_valid[0] = 1'b1;
      req_blk[0]   = 1'b1;
      tick();
      #1;
      total++;
      if (gnt !== 2'b01) begin
         bad++;
         $display("FAIL abort_first_drain_gnt got=%b want=01", gnt);
      end
      tick();
      do_reset();
      total++;
      if (locks !== 32'h0 || state !== 2'd0) begin
         bad++;
         $display("FAIL abort_reset got locks=%h state=%0d want locks=0 state=0", locks, state);
      end
   endtask

   task automatic test_collision();
      do_reset();
      req_valid[0] = 1'b1;
      req_rd[0]    = 5'd7;
      wb_valid     = 1'b1;
      wb_rd        = 5'd7;
      tick();
      total++;
      if (locks !== 32'h80) begin
         bad++;
         $display("FAIL coll_grant_wins got=%h want=00000080", locks);
      end
      clear_inputs();
      req_valid[1] = 1'b1;
      #1;
      total++;
      if (gnt !== 2'b10) begin
         bad++;
         $display("FAIL coll_rd0_gnt got=%b want=10", gnt);
      end
      tick();
      clear_inputs();
      total++;
      if (locks !== 32'h80) begin
         bad++;
         $display("FAIL coll_rd0_locks got=%h want=00000080", locks);
      end
   endtask

   task automatic test_random();
      int            g, nmode, nrr, gi;
      logic [NR-1:0] nlocks;
      logic [NP-1:0] want;
      do_reset();
      m_mode  = 0;
      m_locks = '0;
      m_rr    = 0;
      for (int c = 0; c < 20000; c++) begin
         rand_inputs();
         rst_i = ($urandom % 400) == 0;
         #1;
         if (rst_i) begin
            total++;
            if (gnt !== 2'b00) begin
               bad++;
               $display("FAIL rnd_reset_gnt cyc=%0d got=%b want=00", c, gnt);
            end
            tick();
            m_mode  = 0;
            m_locks = '0;
            m_rr    = 0;
         end else begin
            model_decide(g, nmode, nlocks, nrr);
            want = (g < 0) ? '0 : NP'(1 << g);
            total++;
            if (gnt !== want) begin
               bad++;
               $display("FAIL rnd_gnt cyc=%0d got=%b want=%b", c, gnt, want);
            end
            total++;
            if (!$onehot0(gnt)) begin
               bad++;
               $display("FAIL rnd_onehot cyc=%0d got=%b want=at most one bit", c, gnt);
            end
            gi = -1;
            for (int i = 0; i < NP; i++) if (gnt[i]) gi = i;
            if (gi >= 0) begin
               total++;
               if (state === 2'd2) begin
                  bad++;
                  $display("FAIL rnd_gnt_in_hold cyc=%0d got=%b want=00", c, gnt);
               end
               if (!req_blk[gi]) begin
                  total++;
                  if ((req_mask[gi] & locks) != 0 || (req_rd[gi] != 0 && locks[req_rd[gi]])) begin
                     bad++;
                     $display("FAIL rnd_gnt_locked cyc=%0d req=%0d locks=%h want=unlocked regs", c, gi, locks);
                  end
               end
            end
            tick();
            m_mode  = nmode;
            m_locks = nlocks;
            m_rr    = nrr;
            if (gi >= 0 && !req_blk[gi] && req_rd[gi] != 0) begin
               total++;
               if (locks[req_rd[gi]] !== 1'b1) begin
                  bad++;
                  $display("FAIL rnd_rd_locked cyc=%0d rd=%0d got=0 want=1", c, req_rd[gi]);
               end
            end
         end
         total++;
         if (locks !== m_locks || state !== 2'(m_mode)) begin
            bad++;
            $display("FAIL rnd_state cyc=%0d got locks=%h state=%0d want locks=%h state=%0d",
                     c, locks, state, m_locks, m_mode);
         end
         if (state === 2'd2) begin
            total++;
            if (locks !== '1) begin
               bad++;
               $display("FAIL rnd_hold_all_locked cyc=%0d got=%h want=ffffffff", c, locks);
            end
         end
      end
      rst_i = 1'b0;
      clear_inputs();
   endtask

   initial begin
      rst_i = 1'b1;
      clear_inputs();
      test_reset();
      test_hazard();
      test_round_robin();
      test_blocking();
      test_abort_hold();
      test_collision();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
